vga_sync_decoder: RTL and testbench



---
 rtl/vga_sync_decoder.sv | 140 ++++++++++++++
 tb/tb_vga_sync_decoder.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/vga_sync_decoder.sv
// rtl/vga_sync_decoder.sv - VGA sync receiver: measures line/frame periods, locks, recovers pixel coordinates
module vga_sync_decoder #(
    parameter int H_TOTAL    = 800,
    parameter int H_SYNC     = 96,
    parameter int H_BACK     = 48,
    parameter int H_ACTIVE   = 640,
    parameter int V_TOTAL    = 521,
    parameter int V_SYNC     = 2,
    parameter int V_BACK     = 29,
    parameter int V_ACTIVE   = 480,
    parameter int LOCK_LINES = 4
) (
    input  logic        clk_25,
    input  logic        reset,
    input  logic        h_sync,
    input  logic        v_sync,
    output logic [9:0]  pixel_x,
    output logic [9:0]  pixel_y,
    output logic        active,
    output logic        locked,
    output logic [10:0] line_len,
    output logic        frame_start,
    output logic        sync_err
);

    localparam int          HM_W        = $clog2(LOCK_LINES + 1);
    localparam logic [10:0] H_PERIOD    = 11'(H_TOTAL);
    localparam logic [10:0] V_PERIOD    = 11'(V_TOTAL);
    localparam logic [10:0] H_FIRST     = 11'(H_SYNC + H_BACK);
    localparam logic [10:0] H_LAST      = 11'(H_SYNC + H_BACK + H_ACTIVE - 1);
    localparam logic [10:0] V_FIRST     = 11'(V_SYNC + V_BACK);
    localparam logic [10:0] V_LAST      = 11'(V_SYNC + V_BACK + V_ACTIVE - 1);
    localparam logic [HM_W-1:0] H_MATCH_MAX = HM_W'(LOCK_LINES);
    localparam logic [HM_W-1:0] H_MATCH_PRE = HM_W'(LOCK_LINES - 1);

    logic            h_sync_q, h_sync_qq, v_sync_q, v_sync_qq;
    logic [10:0]     h_cnt;
    logic [9:0]      v_cnt;
    logic [HM_W-1:0] h_match;
    logic [1:0]      v_match;
    logic            h_locked, v_locked, v_pend, frame_evt;

    logic        h_fall, v_fall, new_frame;
    logic        h_good, h_bad, v_good, v_bad;
    logic        h_win, v_win, show;
    logic [10:0] line_period, frame_len, v_cnt_w;

    always_comb begin
        h_fall      = h_sync_qq & ~h_sync_q;
        v_fall      = v_sync_qq & ~v_sync_q;
        new_frame   = h_fall & (v_pend | v_fall);
        line_period = h_cnt + 11'd1;
        v_cnt_w     = {1'b0, v_cnt};
        frame_len   = v_cnt_w + 11'd1;
        h_good      = h_fall & (line_period == H_PERIOD);
        // Saturation is flagged on the step into 2047 so it pulses only once.
        h_bad       = (h_fall & (line_period != H_PERIOD)) | (~h_fall & (h_cnt == 11'd2046));
        v_good      = new_frame & (frame_len == V_PERIOD);
        v_bad       = (new_frame & (frame_len != V_PERIOD))
                    | (h_fall & ~new_frame & (v_cnt == 10'd1022));
        h_win       = (h_cnt >= H_FIRST) && (h_cnt <= H_LAST);
        v_win       = (v_cnt_w >= V_FIRST) && (v_cnt_w <= V_LAST);
        locked      = h_locked & v_locked;
        show        = locked & h_win & v_win;
    end

    always_ff @(posedge clk_25) begin
        if (reset) begin
            h_sync_q    <= 1'b1;
            h_sync_qq   <= 1'b1;
            v_sync_q    <= 1'b1;
            v_sync_qq   <= 1'b1;
            h_cnt       <= '0;
            v_cnt       <= '0;
            h_match     <= '0;
            v_match     <= '0;
            h_locked    <= 1'b0;
            v_locked    <= 1'b0;
            v_pend      <= 1'b0;
            frame_evt   <= 1'b0;
            line_len    <= '0;
            sync_err    <= 1'b0;
            frame_start <= 1'b0;
            active      <= 1'b0;
            pixel_x     <= '0;
            pixel_y     <= '0;
        end else begin
            h_sync_q  <= h_sync;
            h_sync_qq <= h_sync_q;
            v_sync_q  <= v_sync;
            v_sync_qq <= v_sync_q;

            if (h_fall) begin
                h_cnt    <= '0;
                line_len <= line_period;
            end else if (h_cnt != 11'd2047) begin
                h_cnt <= h_cnt + 11'd1;
            end

            if (h_bad) begin
                h_match  <= '0;
                h_locked <= 1'b0;
            end else if (h_good) begin
                if (h_match != H_MATCH_MAX)
                    h_match <= h_match + 1'b1;
                if (h_match >= H_MATCH_PRE)
                    h_locked <= 1'b1;
            end

            // A v fall coincident with an h fall is consumed by that line.
            if (new_frame)
                v_pend <= 1'b0;
            else if (v_fall)
                v_pend <= 1'b1;

            if (new_frame)
                v_cnt <= '0;
            else if (h_fall && v_cnt != 10'd1023)
                v_cnt <= v_cnt + 10'd1;

            if (v_bad) begin
                v_match  <= '0;
                v_locked <= 1'b0;
            end else if (v_good) begin
                if (v_match != 2'd2)
                    v_match <= v_match + 2'd1;
                if (v_match != 2'd0)
                    v_locked <= 1'b1;
            end

            sync_err    <= (h_bad & h_locked) | (v_bad & v_locked);
            frame_evt   <= new_frame;
            frame_start <= frame_evt;
            active      <= show;
            pixel_x     <= show ? 10'(h_cnt - H_FIRST) : 10'd0;
            pixel_y     <= show ? 10'(v_cnt_w - V_FIRST) : 10'd0;
        end
    end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// tb/tb_vga_sync_decoder.sv - scoreboard bench for vga_sync_decoder on a scaled-down raster
module tb_vga_sync_decoder;

    localparam int HT = 40;
    localparam int HS = 4;
    localparam int HB = 6;
    localparam int HA = 24;
    localparam int VT = 12;
    localparam int VS = 1;
    localparam int VB = 2;
    localparam int VA = 8;
    localparam int HF = HS + HB;
    localparam int VF = VS + VB;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        h_sync = 1'b1;
    logic        v_sync = 1'b1;
    logic [9:0]  pixel_x, pixel_y;
    logic        active, locked, frame_start, sync_err;
    logic [10:0] line_len;

    int checks = 0;
    int fails  = 0;

    logic [19:0] exp_pix[$];
    logic [10:0] exp_err[$];
    logic        exp_fs[$];
    logic [19:0] pix_e;
    logic [10:0] err_e;
    logic        fs_e;

    vga_sync_decoder #(
        .H_TOTAL(HT), .H_SYNC(HS), .H_BACK(HB), .H_ACTIVE(HA),
        .V_TOTAL(VT), .V_SYNC(VS), .V_BACK(VB), .V_ACTIVE(VA),
        .LOCK_LINES(4)
    ) dut (
        .clk_25(clk), .reset(reset), .h_sync(h_sync), .v_sync(v_sync),
        .pixel_x(pixel_x), .pixel_y(pixel_y), .active(active), .locked(locked),
        .line_len(line_len), .frame_start(frame_start), .sync_err(sync_err)
    );

    always #20 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (active) begin
            if (exp_pix.size() == 0) begin
                check("unexpected_active", 1, 0);
            end else begin
                pix_e = exp_pix.pop_front();
                check("pixel_x", int'(pixel_x), int'(pix_e[9:0]));
                check("pixel_y", int'(pixel_y), int'(pix_e[19:10]));
            end
        end
        if (sync_err) begin
            if (exp_err.size() == 0) begin
                check("unexpected_sync_err", 1, 0);
            end else begin
                err_e = exp_err.pop_front();
                check("sync_err_line_len", int'(line_len), int'(err_e));
            end
        end
        if (frame_start) begin
            if (exp_fs.size() == 0) begin
                check("unexpected_frame_start", 1, 0);
            end else begin
                fs_e = exp_fs.pop_front();
                check("frame_start_locked", int'(locked), int'(fs_e));
            end
        end
    end

    task automatic check_zero(input string tag);
        check({tag, "_pixel_x"}, int'(pixel_x), 0);
        check({tag, "_pixel_y"}, int'(pixel_y), 0);
        check({tag, "_active"}, int'(active), 0);
        check({tag, "_locked"}, int'(locked), 0);
        check({tag, "_line_len"}, int'(line_len), 0);
        check({tag, "_frame_start"}, int'(frame_start), 0);
        check({tag, "_sync_err"}, int'(sync_err), 0);
    endtask

    task automatic send_line(input int len, input int l, input bit lock,
                             input int vlow_from, input int rst_at);
        if (lock && l >= VF && l < VF + VA)
            for (int c = HF; c < HF + HA; c++)
                exp_pix.push_back({10'(l - VF), 10'(c - HF)});
        for (int c = 0; c < len; c++) begin
            h_sync = (c < HS) ? 1'b0 : 1'b1;
            v_sync = (l < VS || (vlow_from >= 0 && c >= vlow_from)) ? 1'b0 : 1'b1;
            reset  = (c == rst_at);
            @(posedge clk);
            #1;
            if (c == rst_at) begin
                reset = 1'b0;
                check_zero("midframe_reset");
            end
        end
    endtask

    // mask bit l: line l is expected to be decoded while locked
    task automatic send_frame(input int nlines, input logic [15:0] mask, input int short_at,
                              input bit early_next, input int rst_line);
        exp_fs.push_back(mask[0]);
        for (int l = 0; l < nlines; l++)
            send_line((l == short_at) ? HT - 1 : HT, l, mask[l],
                      (early_next && l == nlines - 1) ? 20 : -1,
                      (l == rst_line) ? 37 : -1);
    endtask

    initial begin
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        reset = 1'b0;

        send_frame(VT, 16'h0000, -1, 1'b0, -1);
        send_frame(VT, 16'h0000, -1, 1'b0, -1);
        send_frame(VT, 16'hFFFF, -1, 1'b0, -1);

        exp_err.push_back(11'(HT - 1));
        send_frame(VT, 16'h0C3F, 5, 1'b0, -1);
        send_frame(VT, 16'hFFFF, -1, 1'b0, -1);

        exp_err.push_back(11'(HT));
        h_sync = 1'b1;
        v_sync = 1'b1;
        repeat (2100) @(posedge clk);
        #1;
        check("sat_locked", int'(locked), 0);

        send_frame(VT, 16'h0FF0, -1, 1'b0, -1);
        send_frame(VT, 16'hFFFF, -1, 1'b1, -1);
        send_frame(VT, 16'hFFFF, -1, 1'b0, -1);

        send_frame(VT, 16'h007F, -1, 1'b0, 6);
        send_frame(VT, 16'h0000, -1, 1'b0, -1);
        send_frame(VT, 16'h0000, -1, 1'b0, -1);
        send_frame(VT, 16'hFFFF, -1, 1'b0, -1);

        send_frame(VT - 1, 16'hFFFF, -1, 1'b0, -1);
        exp_err.push_back(11'(HT));
        send_frame(VT, 16'h0000, -1, 1'b0, -1);
        send_frame(VT, 16'h0000, -1, 1'b0, -1);
        send_frame(VT, 16'hFFFF, -1, 1'b0, -1);

        h_sync = 1'b1;
        v_sync = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("final_locked", int'(locked), 1);
        check("final_line_len", int'(line_len), HT);
        check("pixels_left", exp_pix.size(), 0);
        check("sync_err_left", exp_err.size(), 0);
        check("frame_start_left", exp_fs.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
